// File: rtl/mux_scan_serializer_pkg.sv
// Shared constants, state encoding and select-stepping helpers for the
// 16:1 mux scan serializer.
package mux_scan_serializer_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Starting select for a frame: bit 15 for MSB-first, bit 0 for LSB-first.
  function automatic logic [SEL_W-1:0] first_sel(input logic msb);
    return msb ? 4'd15 : 4'd0;
  endfunction

  // Next select in scan order; callers never step past the final bit.
  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] cur,
                                                input logic             msb);
    return msb ? (cur - 4'd1) : (cur + 4'd1);
  endfunction

endpackage

// File: rtl/mux_scan_serializer_mux.sv
// 16:1 bit-select mux: returns data[sel].
module mux_16x1
  import mux_scan_serializer_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  // Pure bit select of the held word.
  always_comb begin
    y = data[sel];
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Serializes a captured 16-bit word through a 16:1 mux, one bit per
// BIT_CYCLES clocks, with per-bit strobe, last flag and end-of-frame pulse.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_msb,
  output logic             load_ready,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int               DIV_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic             msb_r;
  logic [SEL_W-1:0] sel_r;
  logic [3:0]       bit_cnt_r;
  logic [DIV_W-1:0] div_cnt_r;

  logic in_shift_s;
  logic bit_end_s;
  logic strobe_s;
  logic accept_s;
  logic mux_bit_s;

  mux_16x1 u_mux (
    .data (data_r),
    .sel  (sel_r),
    .y    (mux_bit_s)
  );

  // Strobe, last and done are qualified by abort in the same cycle so an
  // aborted frame never reports a completed bit or frame.
  always_comb begin
    in_shift_s = (state_r == ST_SHIFT);
    bit_end_s  = in_shift_s && (div_cnt_r == DIV_LAST);
    strobe_s   = bit_end_s && !abort;
    accept_s   = load_valid && load_ready;
    load_ready = (state_r == ST_IDLE) && !rst;
    sel        = sel_r;
    ser_out    = mux_bit_s && in_shift_s;
    ser_valid  = strobe_s;
    ser_last   = strobe_s && (bit_cnt_r == 4'd15);
    busy       = (state_r != ST_IDLE);
    done       = (state_r == ST_DONE) && !abort;
  end

  // Frame FSM with bit-period divider and select counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      data_r    <= 16'h0000;
      msb_r     <= 1'b0;
      sel_r     <= 4'd0;
      bit_cnt_r <= 4'd0;
      div_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            data_r    <= load_data;
            msb_r     <= load_msb;
            sel_r     <= first_sel(load_msb);
            bit_cnt_r <= 4'd0;
            div_cnt_r <= '0;
            state_r   <= ST_SHIFT;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            sel_r     <= 4'd0;
            bit_cnt_r <= 4'd0;
            div_cnt_r <= '0;
            state_r   <= ST_IDLE;
          end else if (bit_end_s) begin
            div_cnt_r <= '0;
            if (bit_cnt_r == 4'd15) begin
              // Hold sel on the final bit rather than wrapping.
              state_r <= ST_DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              sel_r     <= step_sel(sel_r, msb_r);
              state_r   <= ST_SHIFT;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            state_r   <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          sel_r     <= 4'd0;
          bit_cnt_r <= 4'd0;
          div_cnt_r <= '0;
          state_r   <= ST_IDLE;
        end
        default: begin
          sel_r     <= 4'd0;
          bit_cnt_r <= 4'd0;
          div_cnt_r <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: table of frames on a BIT_CYCLES=1 instance plus
// hand-written sequences for stretched bits, back-to-back loads, abort, reset.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_lv = 1'b0, a_msb = 1'b0, a_abort = 1'b0;
  logic [15:0] a_data = 16'h0000;
  logic        a_ready, a_out, a_valid, a_last, a_busy, a_done;
  logic [3:0]  a_sel;

  logic        b_lv = 1'b0, b_msb = 1'b0, b_abort = 1'b0;
  logic [15:0] b_data = 16'h0000;
  logic        b_ready, b_out, b_valid, b_last, b_busy, b_done;
  logic [3:0]  b_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_scan_serializer #(.BIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_lv), .load_data(a_data),
    .load_msb(a_msb), .load_ready(a_ready), .abort(a_abort), .sel(a_sel),
    .ser_out(a_out), .ser_valid(a_valid), .ser_last(a_last),
    .busy(a_busy), .done(a_done)
  );

  mux_scan_serializer #(.BIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_lv), .load_data(b_data),
    .load_msb(b_msb), .load_ready(b_ready), .abort(b_abort), .sel(b_sel),
    .ser_out(b_out), .ser_valid(b_valid), .ser_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [15:0] data;
    logic        msb;
    logic [15:0] stream;  // bit i = i-th transmitted bit
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a();
    int t;
    t = 0;
    @(negedge clk);
    while (!a_ready && t < 40) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("a_ready_wait", a_ready, 1);
  endtask

  // Load at a negedge, return positioned in the first SHIFT cycle.
  task automatic load_a(input logic [15:0] d, input logic m);
    wait_ready_a();
    a_lv = 1'b1; a_data = d; a_msb = m;
    tick();
    a_lv = 1'b0;
  endtask

  initial begin
    vecs[0] = '{data: 16'hA5C3, msb: 1'b0, stream: 16'hA5C3};
    vecs[1] = '{data: 16'h8001, msb: 1'b1, stream: 16'h8001};
    vecs[2] = '{data: 16'h1234, msb: 1'b1, stream: 16'h2C48};
    vecs[3] = '{data: 16'h0F00, msb: 1'b0, stream: 16'h0F00};

    // Power-on reset
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_out", a_out, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_done", a_done, 0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 1);

    // Table-driven frames, one clock per bit
    for (int k = 0; k < 4; k++) begin
      load_a(vecs[k].data, vecs[k].msb);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        chk("frame_out", a_out, vecs[k].stream[i]);
        chk("frame_sel", a_sel, vecs[k].msb ? (15 - i) : i);
        chk("frame_valid", a_valid, 1);
        chk("frame_last", a_last, (i == 15) ? 1 : 0);
        chk("frame_ready", a_ready, 0);
        tick();
      end
      @(negedge clk);
      chk("frame_done", a_done, 1);
      chk("frame_done_valid", a_valid, 0);
      chk("frame_done_sel", a_sel, vecs[k].msb ? 0 : 15);
      tick();
      @(negedge clk);
      chk("frame_idle_done", a_done, 0);
      chk("frame_idle_busy", a_busy, 0);
    end

    // Three clocks per bit
    @(negedge clk);
    b_lv = 1'b1; b_data = 16'hFFFF; b_msb = 1'b0;
    tick();
    b_lv = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      chk("bc3_out", b_out, 1);
      chk("bc3_valid", b_valid, (c % 3 == 2) ? 1 : 0);
      chk("bc3_last", b_last, (c == 47) ? 1 : 0);
      chk("bc3_sel", b_sel, c / 3);
      tick();
    end
    @(negedge clk);
    chk("bc3_done", b_done, 1);

    // Back-to-back words with load_valid held high
    wait_ready_a();
    a_lv = 1'b1; a_data = 16'h0001; a_msb = 1'b0;
    tick();
    a_data = 16'h0002;
    @(negedge clk);
    chk("b2b_first_bit", a_out, 1);
    chk("b2b_ready_shift", a_ready, 0);
    repeat (15) tick();
    @(negedge clk);
    chk("b2b_last", a_last, 1);
    tick();
    @(negedge clk);
    chk("b2b_done", a_done, 1);
    chk("b2b_ready_done", a_ready, 0);
    tick();
    @(negedge clk);
    chk("b2b_idle_ready", a_ready, 1);
    chk("b2b_idle_busy", a_busy, 0);
    tick();
    a_lv = 1'b0;
    @(negedge clk);
    chk("b2b_second_busy", a_busy, 1);
    chk("b2b_second_bit0", a_out, 0);
    tick();
    @(negedge clk);
    chk("b2b_second_bit1", a_out, 1);
    chk("b2b_second_sel", a_sel, 1);
    repeat (14) tick();
    @(negedge clk);
    chk("b2b_second_last", a_last, 1);
    tick();
    @(negedge clk);
    chk("b2b_second_done", a_done, 1);
    tick();

    // Abort at bit 7
    load_a(16'hA5C3, 1'b0);
    repeat (7) tick();
    a_abort = 1'b1;
    @(negedge clk);
    chk("abort7_valid", a_valid, 0);
    tick();
    a_abort = 1'b0;
    @(negedge clk);
    chk("abort7_busy", a_busy, 0);
    chk("abort7_sel", a_sel, 0);
    chk("abort7_done", a_done, 0);
    chk("abort7_ready", a_ready, 1);

    // Abort coincident with the final strobe
    load_a(16'hFFFF, 1'b1);
    repeat (15) tick();
    a_abort = 1'b1;
    @(negedge clk);
    chk("abortl_valid", a_valid, 0);
    chk("abortl_last", a_last, 0);
    tick();
    a_abort = 1'b0;
    @(negedge clk);
    chk("abortl_done", a_done, 0);
    chk("abortl_busy", a_busy, 0);
    chk("abortl_sel", a_sel, 0);
    tick();
    @(negedge clk);
    chk("abortl_done2", a_done, 0);

    // Reset asserted mid-frame at bit 7
    load_a(16'hA5C3, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_out", a_out, 0);
    chk("mrst_valid", a_valid, 0);
    chk("mrst_last", a_last, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_done", a_done, 0);
    chk("mrst_sel", a_sel, 0);
    chk("mrst_ready", a_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready_after", a_ready, 1);
    chk("mrst_done_after", a_done, 0);
    tick();
    @(negedge clk);
    chk("mrst_done_later", a_done, 0);
    chk("mrst_busy_later", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
